// File: rtl/reg32_rdport16.sv
// reg32_rdport16: coherent multi-beat readback of a wide holding register.
// Snapshots the register on request acceptance and streams it out as BEAT_W-bit
// beats over a valid/ready path, so a load during the transfer cannot tear it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   reg_q               live register value
//   reg_d, reg_ld       register load data / strobe (used with LD_BYPASS_EN)
//   rd_req              read request level, sampled only while idle
//   rd_gnt              1-cycle pulse, snapshot taken on the preceding edge
//   busy                transfer in progress
//   dout, dout_vld      beat data / valid
//   dout_rdy            consumer ready
//   rd_done             1-cycle pulse after the final beat handshake
//
// Optional feature: define LD_BYPASS_EN so that a load coinciding with the
// capture edge snapshots reg_d (the post-load value) instead of reg_q.
module reg32_rdport16 #(
    parameter int WORD_W   = 32,
    parameter int BEAT_W   = 16,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] reg_q,
    input  logic [WORD_W-1:0] reg_d,
    input  logic              reg_ld,
    input  logic              rd_req,
    output logic              rd_gnt,
    output logic              busy,
    output logic [BEAT_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              rd_done
);

    localparam int NBEAT = WORD_W / BEAT_W;
    localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEAT - 1);

    typedef enum logic {
        IDLE,
        BEAT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [NBEAT-1:0][BEAT_W-1:0] snap;
    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             sel;
    logic [WORD_W-1:0]            cap_word;
    logic                         capture;
    logic                         adv;
    logic                         fin;

`ifdef LD_BYPASS_EN
    assign cap_word = reg_ld ? reg_d : reg_q;
`else
    logic unused_ld;
    assign unused_ld = ^{reg_d, reg_ld};
    assign cap_word  = reg_q;
`endif

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        adv      = 1'b0;
        fin      = 1'b0;
        busy     = 1'b0;
        dout_vld = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_req) begin
                    capture  = 1'b1;
                    state_nx = BEAT;
                end
            end
            BEAT: begin
                busy     = 1'b1;
                dout_vld = 1'b1;
                if (dout_rdy) begin
                    if (cnt == LAST) begin
                        fin      = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The counter is left on the last beat after a transfer so that dout
    // keeps showing the final beat while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap    <= '0;
            cnt     <= '0;
            rd_gnt  <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            rd_gnt  <= capture;
            rd_done <= fin;
            if (capture) begin
                snap <= cap_word;
                cnt  <= '0;
            end else if (adv) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Beat index NBEAT-1 of snap is the most significant slice.
    assign sel  = HI_FIRST ? (LAST - cnt) : cnt;
    assign dout = snap[sel];

endmodule
